// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined WIDTH-bit add/subtract, one carry-chained chunk per stage
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int CW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_zero;

  logic              w_adv;
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [WIDTH-1:0]  w_s_nxt [STAGES];
  logic [CW:0]       w_chunk [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_c_nxt;
  logic [STAGES-1:0] w_v_in;

  assign w_adv = !r_v[STAGES-1] || out_ready;

  // Stage 0 consumes the raw inputs; later stages consume the previous stage register.
  always_comb begin
    w_a_in[0] = a;
    w_b_in[0] = sub ? ~b : b;
    w_s_in[0] = '0;
    w_c_in[0] = sub ^ c0;
    w_v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
      w_c_in[k] = r_c[k-1];
      w_v_in[k] = r_v[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_chunk[k] = {1'b0, w_a_in[k][k*CW +: CW]} + {1'b0, w_b_in[k][k*CW +: CW]}
                 + {{CW{1'b0}}, w_c_in[k]};
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*CW +: CW] = w_chunk[k][CW-1:0];
      w_c_nxt[k] = w_chunk[k][CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_c    <= '0;
      r_v    <= '0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_nxt[k];
      end
      r_c    <= w_c_nxt;
      r_v    <= w_v_in;
      // Registered so that zero reads 0 out of reset even though s is all zeros.
      r_zero <= (w_s_nxt[STAGES-1] == '0);
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v[STAGES-1];
  assign s         = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign zero      = r_zero;
  assign overflow  = (r_a[STAGES-1][MSB] == r_b[STAGES-1][MSB]) &&
                     (r_s[STAGES-1][MSB] != r_a[STAGES-1][MSB]);

endmodule
